// File: rtl/butterfly_dif_pipe_if.sv
// Handshake and data bundle for the DIF butterfly pipeline.
// The slave side is the butterfly; the master side drives beats and accepts results.
interface butterfly_dif_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] xr, xi, yr, yi;
  logic [W-1:0] wr, wi;
  logic         inv;
  logic         scale;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ar, ai, br, bi;

  modport master (
    output in_valid, xr, xi, yr, yi, wr, wi, inv, scale, out_ready,
    input  in_ready, out_valid, ar, ai, br, bi
  );

  modport slave (
    input  in_valid, xr, xi, yr, yi, wr, wi, inv, scale, out_ready,
    output in_ready, out_valid, ar, ai, br, bi
  );
endinterface

// File: rtl/butterfly_dif_pipe.sv
// Three-stage radix-2 DIF butterfly: a = x + y, b = (x - y) * w in Q(W-FRAC).FRAC,
// with optional conjugate twiddle and 1/2 scaling; one global stall for all stages.
module butterfly_dif_pipe #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input logic                 clk,
  input logic                 rst,
  butterfly_dif_pipe_if.slave bus
);
  localparam int PW = 2 * W;

  logic adv;

  logic         v1_q, v1_d, scale1_q, scale1_d;
  logic [W-1:0] sr1_q, sr1_d, si1_q, si1_d, dr1_q, dr1_d, di1_q, di1_d;
  logic [W-1:0] wr1_q, wr1_d, wi1_q, wi1_d;

  logic          v2_q, v2_d, scale2_q, scale2_d;
  logic [W-1:0]  sr2_q, sr2_d, si2_q, si2_d;
  logic [PW-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;

  logic         v3_q, v3_d;
  logic [W-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;

  logic [PW-1:0] zr_full, zi_full;
  logic [W-1:0]  zr, zi;
  logic          diff_unused;

  function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    smul = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  endfunction

  function automatic logic [W-1:0] half(input logic [W-1:0] v, input logic en);
    half = en ? {v[W-1], v[W-1:1]} : v;
  endfunction

  assign adv           = !v3_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.ar        = ar_q;
  assign bus.ai        = ai_q;
  assign bus.br        = br_q;
  assign bus.bi        = bi_q;

  always_comb begin
    v1_d     = v1_q;
    scale1_d = scale1_q;
    sr1_d    = sr1_q;
    si1_d    = si1_q;
    dr1_d    = dr1_q;
    di1_d    = di1_q;
    wr1_d    = wr1_q;
    wi1_d    = wi1_q;
    if (adv) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        scale1_d = bus.scale;
        sr1_d    = bus.xr + bus.yr;
        si1_d    = bus.xi + bus.yi;
        dr1_d    = bus.xr - bus.yr;
        di1_d    = bus.xi - bus.yi;
        wr1_d    = bus.wr;
        // Conjugate for the inverse transform; the most negative value wraps to itself.
        wi1_d    = bus.inv ? -bus.wi : bus.wi;
      end
    end
  end

  always_comb begin
    v2_d     = v2_q;
    scale2_d = scale2_q;
    sr2_d    = sr2_q;
    si2_d    = si2_q;
    p0_d     = p0_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    p3_d     = p3_q;
    if (adv) begin
      v2_d = v1_q;
      if (v1_q) begin
        scale2_d = scale1_q;
        sr2_d    = sr1_q;
        si2_d    = si1_q;
        p0_d     = smul(dr1_q, wr1_q);
        p1_d     = smul(di1_q, wi1_q);
        p2_d     = smul(dr1_q, wi1_q);
        p3_d     = smul(di1_q, wr1_q);
      end
    end
  end

  always_comb begin
    // Bits above the kept slice cannot influence it, so the 2W-bit wrap is harmless.
    zr_full     = p0_q - p1_q;
    zi_full     = p2_q + p3_q;
    zr          = zr_full[FRAC+W-1:FRAC];
    zi          = zi_full[FRAC+W-1:FRAC];
    diff_unused = ^{zr_full[PW-1:FRAC+W], zr_full[FRAC-1:0],
                    zi_full[PW-1:FRAC+W], zi_full[FRAC-1:0]};
    v3_d = v3_q;
    ar_d = ar_q;
    ai_d = ai_q;
    br_d = br_q;
    bi_d = bi_q;
    if (adv) begin
      v3_d = v2_q;
      if (v2_q) begin
        ar_d = half(sr2_q, scale2_q);
        ai_d = half(si2_q, scale2_q);
        br_d = half(zr, scale2_q);
        bi_d = half(zi, scale2_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; scale1_q <= 1'b0;
      sr1_q <= '0; si1_q <= '0; dr1_q <= '0; di1_q <= '0; wr1_q <= '0; wi1_q <= '0;
      v2_q <= 1'b0; scale2_q <= 1'b0;
      sr2_q <= '0; si2_q <= '0; p0_q <= '0; p1_q <= '0; p2_q <= '0; p3_q <= '0;
      v3_q <= 1'b0;
      ar_q <= '0; ai_q <= '0; br_q <= '0; bi_q <= '0;
    end else begin
      v1_q <= v1_d; scale1_q <= scale1_d;
      sr1_q <= sr1_d; si1_q <= si1_d; dr1_q <= dr1_d; di1_q <= di1_d;
      wr1_q <= wr1_d; wi1_q <= wi1_d;
      v2_q <= v2_d; scale2_q <= scale2_d;
      sr2_q <= sr2_d; si2_q <= si2_d; p0_q <= p0_d; p1_q <= p1_d; p2_q <= p2_d; p3_q <= p3_d;
      v3_q <= v3_d;
      ar_q <= ar_d; ai_q <= ai_d; br_q <= br_d; bi_q <= bi_d;
    end
  end
endmodule

// File: tb/tb_butterfly_dif_pipe.sv
// Directed bench for butterfly_dif_pipe: table of hand-computed vectors plus
// stream/backpressure, bubble and mid-stream reset sequences.
module tb_butterfly_dif_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  butterfly_dif_pipe_if #(.W(32)) bus ();
  butterfly_dif_pipe #(.W(32), .FRAC(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] xr, xi, yr, yi, wr, wi;
    logic        inv, scale;
    logic [31:0] ar, ai, br, bi;
  } vec_t;

  int checks = 0;
  int passes = 0;
  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v, input logic valid);
    bus.in_valid = valid;
    bus.xr = v.xr; bus.xi = v.xi; bus.yr = v.yr; bus.yi = v.yi;
    bus.wr = v.wr; bus.wi = v.wi; bus.inv = v.inv; bus.scale = v.scale;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.xr = '0; bus.xi = '0; bus.yr = '0; bus.yi = '0;
    bus.wr = '0; bus.wi = '0; bus.inv = 1'b0; bus.scale = 1'b0;
  endtask

  task automatic checkResult(input string tag, input vec_t v);
    checkOutput({tag, ".ar"}, bus.ar, v.ar);
    checkOutput({tag, ".ai"}, bus.ai, v.ai);
    checkOutput({tag, ".br"}, bus.br, v.br);
    checkOutput({tag, ".bi"}, bus.bi, v.bi);
  endtask

  // Stream beats: with w = 1.0 the twiddle product is exact, so b = x - y.
  function automatic vec_t beatVec(input int idx);
    vec_t v;
    logic [31:0] k;
    k = 32'(idx + 1);
    v.xr = k << 16; v.xi = k; v.yr = k; v.yi = k << 8;
    v.wr = 32'h00010000; v.wi = 32'h0; v.inv = 1'b0; v.scale = 1'b0;
    v.ar = v.xr + v.yr; v.ai = v.xi + v.yi;
    v.br = v.xr - v.yr; v.bi = v.xi - v.yi;
    return v;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pat[6];
    int sent, got;
    logic accept, deliver;
    vec_t bv;

    vecs[0] = '{32'h00010000, 32'h0, 32'h00008000, 32'h0, 32'h00010000, 32'h0, 1'b0, 1'b0,
                32'h00018000, 32'h0, 32'h00008000, 32'h0};
    vecs[1] = '{32'h0, 32'h0, 32'hFFFF0000, 32'h0, 32'h0, 32'hFFFF0000, 1'b0, 1'b0,
                32'hFFFF0000, 32'h0, 32'h0, 32'hFFFF0000};
    vecs[2] = '{32'h0, 32'h0, 32'hFFFF0000, 32'h0, 32'h0, 32'hFFFF0000, 1'b1, 1'b0,
                32'hFFFF0000, 32'h0, 32'h0, 32'h00010000};
    vecs[3] = '{32'h00010000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0, 1'b0, 1'b1,
                32'h00010000, 32'h0, 32'h0, 32'h00010000};
    vecs[4] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h00010000, 32'h0, 1'b0, 1'b1,
                32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0};
    vecs[5] = '{32'h00020000, 32'h00010000, 32'h00008000, 32'hFFFF8000, 32'h00008000, 32'h00008000, 1'b0, 1'b0,
                32'h00028000, 32'h00008000, 32'h0, 32'h00018000};
    vecs[6] = '{32'h0, 32'h0, 32'h00000001, 32'h0, 32'h00008000, 32'h0, 1'b0, 1'b0,
                32'h00000001, 32'h0, 32'hFFFFFFFF, 32'h0};
    vecs[7] = '{32'h7FFFFFFF, 32'h0, 32'h00000001, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                32'h80000000, 32'h0, 32'h0, 32'h0};
    vecs[8] = '{32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000, 1'b1, 1'b0,
                32'h00010000, 32'h0, 32'h0, 32'h80000000};
    vecs[9] = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h01000000, 32'h0, 1'b0, 1'b0,
                32'h01000000, 32'h0, 32'h0, 32'h0};
    pat = '{1, 0, 1, 0, 0, 1};

    rst = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);
    checkResult("reset", '{default: 32'h0, inv: 1'b0, scale: 1'b0});
    rst = 1'b0;

    // Table vectors: present at a falling edge, result visible after the third rising edge.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], 1'b1);
      @(posedge clk); @(negedge clk);
      idle();
      checkOutput($sformatf("vec%0d.lat1", i), 32'(bus.out_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("vec%0d.lat2", i), 32'(bus.out_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
      checkResult($sformatf("vec%0d", i), vecs[i]);
    end
    @(posedge clk); @(negedge clk);

    // Bubbles pass through unchanged, three edges later.
    for (int c = 0; c < 9; c++) begin
      if (c < 6) applyStimulus(vecs[0], pat[c] != 0);
      else idle();
      checkOutput($sformatf("bubble.c%0d", c), 32'(bus.out_valid),
                  (c >= 3 && pat[(c >= 3) ? c - 3 : 0] != 0) ? 32'd1 : 32'd0);
      @(posedge clk); @(negedge clk);
    end
    idle();
    @(posedge clk); @(negedge clk);

    // Eight-beat stream with a three-cycle output stall.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (sent < 8) applyStimulus(beatVec(sent), 1'b1);
      else idle();
      bus.out_ready = (c >= 5 && c < 8) ? 1'b0 : 1'b1;
      #1;
      checkOutput($sformatf("stream.in_ready.c%0d", c), 32'(bus.in_ready),
                  (bus.out_valid && !bus.out_ready) ? 32'd0 : 32'd1);
      if (c >= 5 && c < 8)
        checkOutput($sformatf("stream.stall_valid.c%0d", c), 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) checkResult($sformatf("stream.beat%0d.c%0d", got, c), beatVec(got));
      accept  = bus.in_valid && bus.in_ready;
      deliver = bus.out_valid && bus.out_ready;
      @(posedge clk);
      if (accept) sent++;
      if (deliver) got++;
      @(negedge clk);
    end
    checkOutput("stream.sent", 32'(sent), 32'd8);
    checkOutput("stream.got", 32'(got), 32'd8);
    idle();
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);

    // Fill three stages behind a stalled output, then reset.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(beatVec(c), 1'b1);
      @(posedge clk); @(negedge clk);
    end
    idle();
    #1;
    checkOutput("prereset.out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("prereset.in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postreset.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("postreset.in_ready", 32'(bus.in_ready), 32'd1);
    checkResult("postreset", '{default: 32'h0, inv: 1'b0, scale: 1'b0});
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("postreset.empty.c%0d", c), 32'(bus.out_valid), 32'd0);
    end
    bv = vecs[5];
    applyStimulus(bv, 1'b1);
    @(posedge clk); @(negedge clk);
    idle();
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checkOutput("postreset.fresh.out_valid", 32'(bus.out_valid), 32'd1);
    checkResult("postreset.fresh", bv);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
